// File: rtl/cycle_counter_pkg.sv
// Shared constants and helpers for the cycle counter AXI4-Lite register block.
// Register offsets, control/status bit positions, response codes and byte-strobe merge.
package cycle_counter_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'h0;
    localparam logic [3:0] ADDR_NUM_CYCLE = 4'h4;
    localparam logic [3:0] ADDR_STATUS    = 4'h8;
    localparam logic [3:0] ADDR_IRQ       = 4'hC;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int STAT_IDLE_BIT   = 0;
    localparam int STAT_RUN_BIT    = 1;
    localparam int STAT_DONE_BIT   = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cycle_counter_axil_if.sv
// AXI4-Lite slave handshake engine: accepts AW+W together and AR, returns registered
// B and R responses, and exposes simple write/read strobes to the register decode.
module cycle_counter_axil_if
    import cycle_counter_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_err_i,
    input  logic              wr_err_i
);

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    // The ready pulse itself blocks a second acceptance before bvalid/rvalid rise.
    assign wr_en_o   = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign wr_addr_o = s_axi_awaddr;
    assign wr_data_o = s_axi_wdata;
    assign wr_strb_o = s_axi_wstrb;
    assign rd_en_o   = arready_q & s_axi_arvalid;
    assign rd_addr_o = s_axi_araddr;

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    // Next-state for both channel handshakes and the registered responses.
    always_comb begin
        awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (wr_en_o) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = rd_err_i ? 32'd0 : rd_data_i;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/cycle_counter_axil_regs.sv
// AXI4-Lite register file in front of the cycle counter core (count, run, status).
// Optional interrupt register and o_irq output are built when CYCLE_CNT_IRQ_EN is defined.
module cycle_counter_axil_regs
    import cycle_counter_pkg::*;
#(
    parameter int NUM_CYCLE_BIT  = 32,
    parameter int C_S_AXI_ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [C_S_AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [C_S_AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [NUM_CYCLE_BIT-1:0]  o_num_cycle,
    output logic                      o_run,
    input  logic                      i_idle,
    input  logic                      i_running,
`ifdef CYCLE_CNT_IRQ_EN
    output logic                      o_irq,
`endif
    input  logic                      i_done
);

    logic                      wr_en_s, rd_en_s, rd_err_s, wr_err_s, clr_s;
    logic [C_S_AXI_ADDR_W-1:0] wr_addr_s, rd_addr_s;
    logic [31:0]               wr_data_s, rd_data_s, num_ext_s, merged_s;
    logic [3:0]                wr_strb_s, wr_off_s, rd_off_s;
    logic [NUM_CYCLE_BIT-1:0]  num_cycle_q, num_cycle_d;
    logic                      run_q, run_d, done_q, done_d;
    logic                      irq_en_q, irq_en_d, irq_q, irq_d;
    logic                      unused_s;

    cycle_counter_axil_if #(.ADDR_W(C_S_AXI_ADDR_W)) u_if (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_en_o(wr_en_s), .wr_addr_o(wr_addr_s), .wr_data_o(wr_data_s), .wr_strb_o(wr_strb_s),
        .rd_en_o(rd_en_s), .rd_addr_o(rd_addr_s), .rd_data_i(rd_data_s),
        .rd_err_i(rd_err_s), .wr_err_i(wr_err_s)
    );

    assign wr_off_s    = {wr_addr_s[3:2], 2'b00};
    assign rd_off_s    = {rd_addr_s[3:2], 2'b00};
    assign o_num_cycle = num_cycle_q;
    assign o_run       = run_q;
    assign unused_s    = ^{wr_addr_s, rd_addr_s, rd_en_s, irq_en_q, irq_q};
`ifdef CYCLE_CNT_IRQ_EN
    assign o_irq       = irq_q;
`endif

    // Count register zero-extended to the 32-bit bus, and its byte-strobed update.
    always_comb begin
        num_ext_s                      = 32'd0;
        num_ext_s[NUM_CYCLE_BIT-1:0]   = num_cycle_q;
        merged_s                       = apply_wstrb(num_ext_s, wr_data_s, wr_strb_s);
    end

    // Write decode, run pulse and sticky done; a new done beats a same-cycle clear.
    always_comb begin
        num_cycle_d = num_cycle_q;
        run_d       = 1'b0;
        clr_s       = 1'b0;
        irq_en_d    = irq_en_q;
`ifdef CYCLE_CNT_IRQ_EN
        wr_err_s    = 1'b0;
`else
        wr_err_s    = (wr_off_s == ADDR_IRQ);
`endif
        if (wr_en_s) begin
            case (wr_off_s)
                ADDR_CTRL: begin
                    run_d = wr_data_s[CTRL_RUN_BIT] & wr_strb_s[0] & i_idle;
                    clr_s = wr_data_s[CTRL_CLR_BIT] & wr_strb_s[0];
                end
                ADDR_NUM_CYCLE: num_cycle_d = merged_s[NUM_CYCLE_BIT-1:0];
`ifdef CYCLE_CNT_IRQ_EN
                ADDR_IRQ: irq_en_d = wr_strb_s[0] ? wr_data_s[0] : irq_en_q;
`endif
                default: num_cycle_d = num_cycle_q;
            endcase
        end else begin
            num_cycle_d = num_cycle_q;
        end
        if (i_done) begin
            done_d = 1'b1;
        end else if (clr_s || run_q) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        irq_d = irq_en_q & done_q;
    end

    // Read mux; the interface registers it, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data_s = 32'd0;
        rd_err_s  = 1'b0;
        case (rd_off_s)
            ADDR_CTRL:      rd_data_s = 32'd0;
            ADDR_NUM_CYCLE: rd_data_s = num_ext_s;
            ADDR_STATUS:    rd_data_s = {29'd0, done_q, i_running, i_idle};
`ifdef CYCLE_CNT_IRQ_EN
            ADDR_IRQ:       rd_data_s = {30'd0, done_q, irq_en_q};
`endif
            default:        rd_err_s  = 1'b1;
        endcase
    end

    // Register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cycle_q <= '0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            num_cycle_q <= num_cycle_d;
            run_q       <= run_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_cycle_counter_axil_regs.sv
// Directed bench for cycle_counter_axil_regs: register vector table plus handshake,
// run/done and back-pressure sequences. Define CYCLE_CNT_IRQ_EN to cover the IRQ register.
module tb_cycle_counter_axil_regs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  awaddr = 4'h0, araddr = 4'h0, wstrb = 4'h0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, num_cycle;
    logic        run, irq;
    logic        idle = 1'b1, running = 1'b0, done = 1'b0;
    int          total = 0, bad = 0, run_cnt = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    always @(negedge clk) if (run) run_cnt++;

    cycle_counter_axil_regs #(.NUM_CYCLE_BIT(32), .C_S_AXI_ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .o_num_cycle(num_cycle), .o_run(run), .i_idle(idle), .i_running(running),
`ifdef CYCLE_CNT_IRQ_EN
        .o_irq(irq),
`endif
        .i_done(done)
    );
`ifndef CYCLE_CNT_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_sig(input string name, input int which);
        int n = 0;
        while (n < 20) begin
            if ((which == 0 && awready) || (which == 1 && bvalid) ||
                (which == 2 && arready) || (which == 3 && rvalid)) break;
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_sig("awready", 0);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_sig("bvalid", 1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        wait_sig("arready", 2);
        @(negedge clk);
        arvalid = 1'b0;
        wait_sig("rvalid", 3);
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    initial begin
        logic [31:0] d, held;
        logic [1:0]  r;
        int          base;

        vecs[0]  = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h0000_0001};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0010, 4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h0000_0010};
        vecs[3]  = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h00BB_00DD};
        vecs[5]  = '{1'b1, 4'h4, 32'h1122_3344, 4'h8, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h11BB_00DD};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h0000_0001};
`ifdef CYCLE_CNT_IRQ_EN
        vecs[10] = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b00, 32'h0};
`else
        vecs[10] = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b10, 32'h0};
`endif
        vecs[11] = '{1'b1, 4'h4, 32'h0000_0010, 4'hF, 2'b00, 32'h0};

        repeat (3) @(negedge clk);
        check("reset_bvalid", {31'd0, bvalid}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_awready", {31'd0, awready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_run", {31'd0, run}, 32'd0);
        check("reset_num_cycle", num_cycle, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
        end
        check("num_cycle_out", num_cycle, 32'h0000_0010);
        check("no_spurious_run", run_cnt, 0);

        // Run with idle core: exactly one o_run cycle.
        base = run_cnt;
        axi_write(4'h0, 32'h1, 4'hF, r);
        repeat (4) @(negedge clk);
        check("run_pulse_count", run_cnt - base, 1);
        // RUN without byte-0 strobe is ignored.
        base = run_cnt;
        axi_write(4'h0, 32'h1, 4'h2, r);
        repeat (4) @(negedge clk);
        check("run_nostrb_count", run_cnt - base, 0);

        idle = 1'b0;
        pulse_done();
        axi_read(4'h8, d, r);
        check("status_done", d, 32'h0000_0004);

        // Run request while busy: dropped, OKAY, done_sticky kept.
        base = run_cnt;
        axi_write(4'h0, 32'h1, 4'hF, r);
        check("busy_run_bresp", {30'd0, r}, 32'd0);
        repeat (4) @(negedge clk);
        check("busy_run_count", run_cnt - base, 0);
        axi_read(4'h8, d, r);
        check("busy_done_kept", d, 32'h0000_0004);

        // Clear, then i_done and CLR_DONE in the same acceptance cycle.
        axi_write(4'h0, 32'h2, 4'hF, r);
        axi_read(4'h8, d, r);
        check("clr_done", d, 32'h0);
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_sig("awready_race", 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        wait_sig("bvalid_race", 1);
        @(negedge clk);
        bready = 1'b0;
        axi_read(4'h8, d, r);
        check("set_beats_clear", d, 32'h0000_0004);
        axi_write(4'h0, 32'h2, 4'hF, r);

`ifdef CYCLE_CNT_IRQ_EN
        axi_write(4'hC, 32'h1, 4'hF, r);
        axi_read(4'hC, d, r);
        check("irq_en_read", d, 32'h0000_0001);
        pulse_done();
        @(negedge clk);
        check("irq_high", {31'd0, irq}, 32'd1);
        axi_read(4'hC, d, r);
        check("irq_pending", d, 32'h0000_0003);
        axi_write(4'h0, 32'h2, 4'hF, r);
        @(negedge clk);
        check("irq_low", {31'd0, irq}, 32'd0);
`endif

        // Write back-pressure: bvalid held, second write not accepted.
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_sig("awready_bp", 0);
        @(negedge clk);
        wdata = 32'h77;
        wait_sig("bvalid_bp", 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_bvalid", {31'd0, bvalid}, 32'd1);
            check("bp_awready", {31'd0, awready}, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_num_cycle", num_cycle, 32'h55);
        bready = 1'b1;
        @(negedge clk);
        check("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
        bready = 1'b0;

        // Read back-pressure: rvalid and rdata stable, no new AR acceptance.
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        wait_sig("arready_bp", 2);
        @(negedge clk);
        araddr = 4'h8;
        wait_sig("rvalid_bp", 3);
        held = rdata;
        check("bp_rdata", held, 32'h55);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_stable", rdata, held);
            check("bp_arready", {31'd0, arready}, 32'd0);
        end

        // Reset while rvalid pending: everything drops at once.
        reset_n = 1'b0;
        #1;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_num_cycle", num_cycle, 32'd0);
        arvalid = 1'b0;
        idle = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        axi_read(4'h8, d, r);
        check("post_rst_status", d, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
